// File: rtl/mag_ambm_stream_pkg.sv
// Shared constants for the AMBM magnitude estimator.
// Segment boundaries are Q0.8 (min/max ratio); alpha/beta are Q2.8.
package mag_ambm_stream_pkg;
    localparam int FRAC    = 8;
    localparam int NSEG    = 8;
    localparam int SEG   [0:7] = '{25, 51, 78, 106, 137, 171, 200, 210};
    localparam int ALPHA [0:8] = '{307, 254, 250, 243, 234, 223, 209, 209, 181};
    localparam int BETA  [0:8] = '{6, 31, 56, 80, 104, 126, 147, 147, 180};
    localparam int ALPHA_S = 246;
    localparam int BETA_S  = 102;

    typedef enum logic {
        MODE_SEG    = 1'b0,
        MODE_SINGLE = 1'b1
    } mode_e;
endpackage

// File: rtl/mag_ambm_stream_if.sv
// Sample-in / magnitude-out stream plus the per-frame peak report.
interface mag_ambm_stream_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int IDX_W = 12
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_re;
    logic signed [IN_W-1:0]  in_im;
    logic                    in_last;
    logic                    cfg_mode;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_mag;
    logic                    out_last;
    logic                    peak_valid;
    logic [OUT_W-1:0]        peak_mag;
    logic [IDX_W-1:0]        peak_idx;

    modport master (
        output in_valid, in_re, in_im, in_last, cfg_mode, out_ready,
        input  in_ready, out_valid, out_mag, out_last, peak_valid, peak_mag, peak_idx
    );
    modport slave (
        input  in_valid, in_re, in_im, in_last, cfg_mode, out_ready,
        output in_ready, out_valid, out_mag, out_last, peak_valid, peak_mag, peak_idx
    );
endinterface

// File: rtl/mag_peak_track.sv
// Per-frame peak tracker: records the first largest magnitude and its index.
// Latency: report pulses the cycle after the handshake carrying the frame's last flag.
// Backpressure: none; only observes completed output handshakes.
module mag_peak_track #(
    parameter int OUT_W = 16,
    parameter int IDX_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hs,
    input  logic [OUT_W-1:0] mag,
    input  logic             last,
    output logic             peak_valid,
    output logic [OUT_W-1:0] peak_mag,
    output logic [IDX_W-1:0] peak_idx
);
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] cur_idx;
    logic [OUT_W-1:0] cur_pk;
    logic             take;
    logic [OUT_W-1:0] nxt_pk;
    logic [IDX_W-1:0] nxt_idx;

    // cnt never wraps, so cnt==0 identifies the first sample of a frame
    always_comb begin
        take    = (cnt == '0) || (mag > cur_pk);
        nxt_pk  = take ? mag : cur_pk;
        nxt_idx = take ? cnt : cur_idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            cur_idx    <= '0;
            cur_pk     <= '0;
            peak_valid <= 1'b0;
            peak_mag   <= '0;
            peak_idx   <= '0;
        end else begin
            peak_valid <= 1'b0;
            if (hs) begin
                if (last) begin
                    peak_valid <= 1'b1;
                    peak_mag   <= nxt_pk;
                    peak_idx   <= nxt_idx;
                    cnt        <= '0;
                    cur_pk     <= '0;
                    cur_idx    <= '0;
                end else begin
                    cnt     <= (cnt == {IDX_W{1'b1}}) ? cnt : cnt + 1'b1;
                    cur_pk  <= nxt_pk;
                    cur_idx <= nxt_idx;
                end
            end
        end
    end
endmodule

// File: rtl/mag_ambm_stream.sv
// Streaming complex magnitude estimate (alpha*max + beta*min) with per-frame peak report.
// Latency: 4 cycles accept-to-output handshake when not stalled; 1 sample/cycle.
// Backpressure: one global enable freezes every stage while out_valid && !out_ready.
module mag_ambm_stream #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int IDX_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    mag_ambm_stream_if.slave io
);
    import mag_ambm_stream_pkg::*;

    localparam int PW = IN_W + 9;
    localparam int SW = ((PW + 1) > (OUT_W + 1)) ? (PW + 1) : (OUT_W + 1);

    logic en;
    assign en          = !io.out_valid || io.out_ready;
    assign io.in_ready = en;

    // the most negative input has no positive twin, so it clips to the largest positive
    function automatic logic [IN_W-1:0] abs_sat(input logic signed [IN_W-1:0] v);
        logic [IN_W-1:0] r;
        if (!v[IN_W-1])               r = v;
        else if (v[IN_W-2:0] == '0)   r = {1'b0, {(IN_W-1){1'b1}}};
        else                          r = -v;
        return r;
    endfunction

    logic [IN_W-1:0] a_re, a_im;
    assign a_re = abs_sat(io.in_re);
    assign a_im = abs_sat(io.in_im);

    logic            s1_vld, s1_last;
    mode_e           s1_mode;
    logic [IN_W-1:0] s1_max, s1_min;

    logic            s2_vld, s2_last, s2_zero;
    logic [IN_W-1:0] s2_max, s2_min;
    logic [8:0]      s2_alpha, s2_beta;

    logic            s3_vld, s3_last, s3_zero;
    logic [PW-1:0]   s3_pa, s3_pb;

    logic [PW-1:0]   left;
    logic [3:0]      seg;
    logic [8:0]      alpha, beta;
    logic [SW-1:0]   sum;

    // descending scan so the lowest matching segment wins
    always_comb begin
        left = PW'(s1_min) << FRAC;
        seg  = 4'(NSEG);
        for (int k = NSEG - 1; k >= 0; k--) begin
            if (left < PW'(s1_max) * PW'(SEG[k]))
                seg = 4'(k);
        end
        if (s1_mode == MODE_SINGLE) begin
            alpha = 9'(ALPHA_S);
            beta  = 9'(BETA_S);
        end else begin
            alpha = 9'(ALPHA[seg]);
            beta  = 9'(BETA[seg]);
        end
    end

    assign sum = SW'(s3_pa) + SW'(s3_pb);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld <= 1'b0; s1_last <= 1'b0; s1_mode <= MODE_SEG;
            s1_max <= '0;   s1_min  <= '0;
            s2_vld <= 1'b0; s2_last <= 1'b0; s2_zero <= 1'b0;
            s2_max <= '0;   s2_min  <= '0;   s2_alpha <= '0; s2_beta <= '0;
            s3_vld <= 1'b0; s3_last <= 1'b0; s3_zero <= 1'b0;
            s3_pa  <= '0;   s3_pb   <= '0;
            io.out_valid <= 1'b0;
            io.out_last  <= 1'b0;
            io.out_mag   <= '0;
        end else if (en) begin
            s1_vld   <= io.in_valid;
            s1_last  <= io.in_last;
            s1_mode  <= mode_e'(io.cfg_mode);
            s1_max   <= (a_re >= a_im) ? a_re : a_im;
            s1_min   <= (a_re >= a_im) ? a_im : a_re;

            s2_vld   <= s1_vld;
            s2_last  <= s1_last;
            s2_zero  <= (s1_max == '0);
            s2_max   <= s1_max;
            s2_min   <= s1_min;
            s2_alpha <= alpha;
            s2_beta  <= beta;

            // each term is floored on its own before the add
            s3_vld   <= s2_vld;
            s3_last  <= s2_last;
            s3_zero  <= s2_zero;
            s3_pa    <= (PW'(s2_max) * PW'(s2_alpha)) >> FRAC;
            s3_pb    <= (PW'(s2_min) * PW'(s2_beta)) >> FRAC;

            io.out_valid <= s3_vld;
            io.out_last  <= s3_last;
            if (s3_zero)
                io.out_mag <= '0;
            else if (sum > SW'({OUT_W{1'b1}}))
                io.out_mag <= {OUT_W{1'b1}};
            else
                io.out_mag <= OUT_W'(sum);
        end
    end

    logic out_hs;
    assign out_hs = io.out_valid && io.out_ready;

    mag_peak_track #(.OUT_W(OUT_W), .IDX_W(IDX_W)) u_peak (
        .clk        (clk),
        .rst        (rst),
        .hs         (out_hs),
        .mag        (io.out_mag),
        .last       (io.out_last),
        .peak_valid (io.peak_valid),
        .peak_mag   (io.peak_mag),
        .peak_idx   (io.peak_idx)
    );
endmodule

// File: doc/mag_ambm_stream.md
MAG_AMBM_STREAM -- requirements
Module: mag_ambm_stream

Interface
REQ-001 SHALL have parameter IN_W, default 16: signed width of each input component.
REQ-002 SHALL have parameter OUT_W, default 16: unsigned width of the magnitude output.
REQ-003 SHALL have parameter IDX_W, default 12: width of the in-frame sample index.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_re (input, IN_W), in_im (input, IN_W), in_last (input, 1) and cfg_mode (input, 1): the input sample, its frame-end flag and its mode (0 = segmented AMBM, 1 = single-coefficient).
REQ-007 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_mag (output, OUT_W) and out_last (output, 1): the magnitude stream.
REQ-008 SHALL have ports peak_valid (output, 1), peak_mag (output, OUT_W) and peak_idx (output, IDX_W): the per-frame peak report.

Function
REQ-009 SHALL accept an input on a clk edge with in_valid=1 and in_ready=1, and emit it on a clk edge with out_valid=1 and out_ready=1.
REQ-010 SHALL use a 4-stage pipeline (abs/max/min; segment compare; coefficient multiply and >>FRAC; add/saturate) with latency exactly 4 cycles when not stalled.
REQ-011 SHALL use a global advance enable en = !out_valid | out_ready, with in_ready = en, so every stage holds while stalled.
REQ-012 SHALL keep out_mag and out_last stable while out_valid=1 and out_ready=0.
REQ-013 SHALL sustain 1 sample/cycle when out_ready=1, with no bubbles.
REQ-014 SHALL form abs() saturating: -2^(IN_W-1) maps to 2^(IN_W-1)-1; then max = larger abs, min = smaller abs.
REQ-015 SHALL, in mode 0, compute left = min<<8 and right_k = max*SEG[k] for k=0..7, pick the first k with left<right_k, and otherwise pick segment 8.
REQ-016 SHALL, in mode 1, use ALPHA_S/BETA_S for every sample.
REQ-017 SHALL force out_mag = 0 when max = 0, in either mode.
REQ-018 SHALL compute out_mag = floor(alpha*max/2^FRAC) + floor(beta*min/2^FRAC), with each product shifted separately, at full internal width.
REQ-019 SHALL saturate out_mag to 2^OUT_W-1 if the sum exceeds it (no truncation).
REQ-020 SHALL carry cfg_mode and in_last with their sample through the pipeline.
REQ-021 SHALL run a peak tracker on output handshakes only, with sample index counting from 0 per frame and saturating at 2^IDX_W-1.
REQ-022 SHALL update the peak when out_mag > current peak (strict, so the first occurrence wins ties); the first sample of a frame always loads the peak.
REQ-023 SHALL, on a handshake with out_last=1, include that sample, then on the next cycle pulse peak_valid for 1 cycle with peak_mag/peak_idx, and restart the index and peak for a new frame.
REQ-024 SHALL hold peak_mag/peak_idx until the next report.
REQ-025 SHALL treat back-to-back single-sample frames as valid, producing one report per frame.

Reset
REQ-026 SHALL, while rst=0, clear all stage valids, out_valid, out_last and peak_valid, and zero out_mag, peak_mag, peak_idx, the index counter and the peak.
REQ-027 SHALL drive in_ready=1 during and after reset.
REQ-028 SHALL, on reset mid-frame or mid-stall, discard in-flight samples and the partial frame, with no report issued.

Structure
REQ-029 SHALL place FRAC=8, SEG[0..7]={25,51,78,106,137,171,200,210} (Q0.8), ALPHA[0..8]={307,254,250,243,234,223,209,209,181} and BETA[0..8]={6,31,56,80,104,126,147,147,180} (Q2.8), and ALPHA_S=246, BETA_S=102 in the shared data_type package.
REQ-030 SHALL implement the peak tracker as sub-module mag_peak_track; the datapath stays in the top module.

Verification
REQ-031 SHALL cover: mode 0, (3000,-4000), out_ready=1 -> out_mag=4987 (segment 6) exactly 4 cycles after accept.
REQ-032 SHALL cover: mode 1, (3000,4000) -> out_mag=5038; (0,0) in both modes -> 0.
REQ-033 SHALL cover: OUT_W=15, mode 0, (-32768,-32768) -> abs saturates to 32767, segment 8, raw sum 46206, out_mag=32767.
REQ-034 SHALL cover: 8-sample stream with out_ready low for cycles 3-6 -> in_ready=0 during the stall, output order and values unchanged, out_mag stable while stalled.
REQ-035 SHALL cover: frame mags {10,50,50,20}, last on 4th -> peak_valid one cycle after the 4th handshake, peak_mag=50, peak_idx=1.
REQ-036 SHALL cover: rst asserted with 3 samples in flight -> out_valid=0 immediately, no peak_valid, next frame's indices start at 0.
